// File: rtl/wb_sram_arbiter.sv
// wb_sram_arbiter
// Shares one Wishbone SRAM-controller slave port between an instruction-fetch
// master (master 0) and a data-access master (master 1). Arbitration is
// round-robin and registered in IDLE; the winner keeps the bus for as long as
// it holds cyc, so locked multi-beat sequences are never split. A watchdog
// turns a slave that never acks into a one-cycle err pulse to the owning
// master and parks the bus in DRAIN until that master lets go of cyc.
//
// Handshake: on each port a beat is requested while cyc & stb are high
// (the "valid" side) and completes in the cycle ack (or err) is high (the
// "ready" side); the address/data/select/we must stay stable until then.
// The arbiter adds no storage in the request or response path: in BUSY the
// granted master's request goes straight through to the slave and the slave
// ack comes straight back, so beats can complete every cycle.
module wb_sram_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    // master 0: instruction fetch
    input  logic                    wbm0_cyc_i,
    input  logic                    wbm0_stb_i,
    input  logic                    wbm0_we_i,
    input  logic [ADDR_WIDTH-1:0]   wbm0_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm0_dat_i,
    input  logic [DATA_WIDTH/8-1:0] wbm0_sel_i,
    output logic [DATA_WIDTH-1:0]   wbm0_dat_o,
    output logic                    wbm0_ack_o,
    output logic                    wbm0_err_o,

    // master 1: data access
    input  logic                    wbm1_cyc_i,
    input  logic                    wbm1_stb_i,
    input  logic                    wbm1_we_i,
    input  logic [ADDR_WIDTH-1:0]   wbm1_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm1_dat_i,
    input  logic [DATA_WIDTH/8-1:0] wbm1_sel_i,
    output logic [DATA_WIDTH-1:0]   wbm1_dat_o,
    output logic                    wbm1_ack_o,
    output logic                    wbm1_err_o,

    // shared SRAM controller slave port
    output logic                    wbs_cyc_o,
    output logic                    wbs_stb_o,
    output logic                    wbs_we_o,
    output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
    output logic [DATA_WIDTH-1:0]   wbs_dat_o,
    output logic [DATA_WIDTH/8-1:0] wbs_sel_o,
    input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
    input  logic                    wbs_ack_i,

    // current FSM state (IDLE=0, BUSY=1, DRAIN=2) for debug and checkers
    output logic [1:0]              dbg_state_o
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   grant_q, grant_d;
    logic                   last_grant_q, last_grant_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [1:0]             err_q, err_d;

    logic                   req0, req1;
    logic                   g_cyc, g_stb, g_we;
    logic [ADDR_WIDTH-1:0]  g_adr;
    logic [DATA_WIDTH-1:0]  g_dat;
    logic [SEL_WIDTH-1:0]   g_sel;

    assign req0 = wbm0_cyc_i & wbm0_stb_i;
    assign req1 = wbm1_cyc_i & wbm1_stb_i;

    // Select the granted master's request signals; used both as the slave
    // drive in BUSY and as the "owner still holds cyc" test in BUSY/DRAIN.
    always_comb begin
        g_cyc = wbm0_cyc_i;
        g_stb = wbm0_stb_i;
        g_we  = wbm0_we_i;
        g_adr = wbm0_adr_i;
        g_dat = wbm0_dat_i;
        g_sel = wbm0_sel_i;
        if (grant_q) begin
            g_cyc = wbm1_cyc_i;
            g_stb = wbm1_stb_i;
            g_we  = wbm1_we_i;
            g_adr = wbm1_adr_i;
            g_dat = wbm1_dat_i;
            g_sel = wbm1_sel_i;
        end
    end

    // State, grant, watchdog and error-pulse registers; reset releases the bus at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;   // so master 0 wins the first tie
            cnt_q        <= '0;
            err_q        <= 2'b00;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, watch the owner's cycle in BUSY,
    // wait for the owner to give up after a timeout in DRAIN.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        err_d        = 2'b00;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (req0 && req1) begin
                    grant_d = ~last_grant_q;
                    state_d = ST_BUSY;
                end else if (req0) begin
                    grant_d = 1'b0;
                    state_d = ST_BUSY;
                end else if (req1) begin
                    grant_d = 1'b1;
                    state_d = ST_BUSY;
                end
            end

            ST_BUSY: begin
                if (!g_cyc) begin
                    // owner ended its bus cycle; re-arbitrate from IDLE
                    last_grant_d = grant_q;
                    cnt_d        = '0;
                    state_d      = ST_IDLE;
                end else if (g_stb && !wbs_ack_i) begin
                    if (cnt_q == CNT_LAST) begin
                        // last allowed unacked strobe cycle: an ack here would
                        // have taken the other branch, so this is a real timeout
                        err_d[grant_q] = 1'b1;
                        cnt_d          = '0;
                        state_d        = ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end

            ST_DRAIN: begin
                cnt_d = '0;
                if (!g_cyc) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Slave drive and ack return: only BUSY connects the owner to the slave;
    // IDLE and DRAIN hold the slave port quiet and swallow any stray ack.
    always_comb begin
        wbs_cyc_o  = 1'b0;
        wbs_stb_o  = 1'b0;
        wbs_we_o   = 1'b0;
        wbs_adr_o  = '0;
        wbs_dat_o  = '0;
        wbs_sel_o  = '0;
        wbm0_ack_o = 1'b0;
        wbm1_ack_o = 1'b0;
        if (state_q == ST_BUSY) begin
            wbs_cyc_o  = g_cyc;
            wbs_stb_o  = g_stb;
            wbs_we_o   = g_we;
            wbs_adr_o  = g_adr;
            wbs_dat_o  = g_dat;
            wbs_sel_o  = g_sel;
            wbm0_ack_o = wbs_ack_i & ~grant_q;
            wbm1_ack_o = wbs_ack_i &  grant_q;
        end
    end

    // Read data is broadcast; each master qualifies it with its own ack.
    assign wbm0_dat_o = wbs_dat_i;
    assign wbm1_dat_o = wbs_dat_i;

    // Error pulses come straight from their registers; err is only raised on
    // entry to DRAIN where acks are blocked, so ack and err never coincide.
    assign wbm0_err_o = err_q[0];
    assign wbm1_err_o = err_q[1];

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_sram_arbiter.sv
// Bench for wb_sram_arbiter: a latency-programmable slave model, per-master
// expected read-data queues checked on every ack, a table of single
// transfers, and hand-written sequences for arbitration order, locked bursts,
// the watchdog and asynchronous reset.
module tb_wb_sram_arbiter;

    localparam int          AW     = 32;
    localparam int          DW     = 32;
    localparam int          SW     = DW / 8;
    localparam logic [31:0] RD_KEY = 32'h5EAD_BEFF;  // slave data = adr ^ RD_KEY

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          wbm0_cyc_i, wbm0_stb_i, wbm0_we_i;
    logic [AW-1:0] wbm0_adr_i;
    logic [DW-1:0] wbm0_dat_i;
    logic [SW-1:0] wbm0_sel_i;
    logic [DW-1:0] wbm0_dat_o;
    logic          wbm0_ack_o, wbm0_err_o;
    logic          wbm1_cyc_i, wbm1_stb_i, wbm1_we_i;
    logic [AW-1:0] wbm1_adr_i;
    logic [DW-1:0] wbm1_dat_i;
    logic [SW-1:0] wbm1_sel_i;
    logic [DW-1:0] wbm1_dat_o;
    logic          wbm1_ack_o, wbm1_err_o;
    logic          wbs_cyc_o, wbs_stb_o, wbs_we_o;
    logic [AW-1:0] wbs_adr_o;
    logic [DW-1:0] wbs_dat_o;
    logic [SW-1:0] wbs_sel_o;
    logic [DW-1:0] wbs_dat_i = '0;
    logic          wbs_ack_i;
    logic [1:0]    dbg_state_o;

    logic slv_ack   = 1'b0;
    logic force_ack = 1'b0;
    int   slave_lat = 1;    // ack in this strobe cycle of a beat; 0 = never ack
    int   slv_cnt   = 0;

    assign wbs_ack_i = slv_ack | force_ack;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp0_q[$];
    logic [DW-1:0] exp1_q[$];
    int ack_order[$];

    typedef struct {
        bit          m;
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        int          lat;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    wb_sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wbm0_cyc_i(wbm0_cyc_i), .wbm0_stb_i(wbm0_stb_i), .wbm0_we_i(wbm0_we_i),
        .wbm0_adr_i(wbm0_adr_i), .wbm0_dat_i(wbm0_dat_i), .wbm0_sel_i(wbm0_sel_i),
        .wbm0_dat_o(wbm0_dat_o), .wbm0_ack_o(wbm0_ack_o), .wbm0_err_o(wbm0_err_o),
        .wbm1_cyc_i(wbm1_cyc_i), .wbm1_stb_i(wbm1_stb_i), .wbm1_we_i(wbm1_we_i),
        .wbm1_adr_i(wbm1_adr_i), .wbm1_dat_i(wbm1_dat_i), .wbm1_sel_i(wbm1_sel_i),
        .wbm1_dat_o(wbm1_dat_o), .wbm1_ack_o(wbm1_ack_o), .wbm1_err_o(wbm1_err_o),
        .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
        .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i),
        .dbg_state_o(dbg_state_o)
    );

    // clock
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_m(input bit m, input logic cyc, input logic stb, input logic we,
                           input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        if (m == 1'b0) begin
            wbm0_cyc_i = cyc; wbm0_stb_i = stb; wbm0_we_i = we;
            wbm0_adr_i = adr; wbm0_dat_i = dat; wbm0_sel_i = sel;
        end else begin
            wbm1_cyc_i = cyc; wbm1_stb_i = stb; wbm1_we_i = we;
            wbm1_adr_i = adr; wbm1_dat_i = dat; wbm1_sel_i = sel;
        end
    endtask

    task automatic push_exp(input bit m, input logic [31:0] val);
        if (m == 1'b0) exp0_q.push_back(val);
        else           exp1_q.push_back(val);
    endtask

    function automatic logic ack_of(input bit m);
        return m ? wbm1_ack_o : wbm0_ack_o;
    endfunction

    // Slave model: samples the bus 2 ns after each edge, acks one beat after
    // slave_lat strobe cycles, returning adr ^ RD_KEY as read data.
    always @(posedge clk_i) begin
        #2;
        if (rst_i) begin
            slv_ack = 1'b0;
            slv_cnt = 0;
        end else begin
            if (slv_ack) begin
                slv_ack = 1'b0;
                slv_cnt = 0;
            end
            if (wbs_cyc_o && wbs_stb_o) begin
                slv_cnt++;
                if (slave_lat > 0 && slv_cnt == slave_lat) begin
                    slv_ack   = 1'b1;
                    wbs_dat_i = wbs_adr_o ^ RD_KEY;
                end
            end else begin
                slv_cnt = 0;
            end
        end
    end

    // Scoreboard monitor: every ack pops that master's expected data.
    always @(negedge clk_i) begin
        check("m0_ack_err_exclusive", 32'(wbm0_ack_o & wbm0_err_o), 32'd0);
        check("m1_ack_err_exclusive", 32'(wbm1_ack_o & wbm1_err_o), 32'd0);
        if (wbm0_ack_o) begin
            ack_order.push_back(0);
            check("m0_ack_expected", 32'(exp0_q.size() > 0), 32'd1);
            if (exp0_q.size() > 0) check("m0_rdata", wbm0_dat_o, exp0_q.pop_front());
        end
        if (wbm1_ack_o) begin
            ack_order.push_back(1);
            check("m1_ack_expected", 32'(exp1_q.size() > 0), 32'd1);
            if (exp1_q.size() > 0) check("m1_rdata", wbm1_dat_o, exp1_q.pop_front());
        end
    end

    task automatic do_reset();
        rst_i     = 1'b1;
        force_ack = 1'b0;
        drive_m(1'b0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        drive_m(1'b1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(posedge clk_i);
        #1;
        exp0_q.delete();
        exp1_q.delete();
        ack_order.delete();
        rst_i = 1'b0;
    endtask

    // One table entry: single transfer by one master on an idle bus.
    task automatic run_vec(input vec_t v, input int idx);
        int k;
        bit got;
        slave_lat = v.lat;
        @(posedge clk_i); #1;
        push_exp(v.m, v.exp_rdata);
        drive_m(v.m, 1, 1, v.we, v.adr, v.wdat, v.sel);
        @(negedge clk_i);
        check($sformatf("v%0d_cyc_not_yet", idx), 32'(wbs_cyc_o), 32'd0);
        @(negedge clk_i);
        check($sformatf("v%0d_cyc_granted", idx), 32'(wbs_cyc_o), 32'd1);
        check($sformatf("v%0d_slave_adr", idx), wbs_adr_o, v.adr);
        check($sformatf("v%0d_slave_we", idx), 32'(wbs_we_o), 32'(v.we));
        check($sformatf("v%0d_slave_dat", idx), wbs_dat_o, v.wdat);
        check($sformatf("v%0d_slave_sel", idx), 32'(wbs_sel_o), 32'(v.sel));
        got = 0;
        k   = 1;
        while (!got && k <= 40) begin
            if (ack_of(v.m)) got = 1;
            else begin
                k++;
                @(negedge clk_i);
            end
        end
        check($sformatf("v%0d_ack_cycle", idx), k, v.lat);
        check($sformatf("v%0d_other_ack", idx), 32'(ack_of(~v.m)), 32'd0);
        @(posedge clk_i); #1;
        drive_m(v.m, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        @(negedge clk_i);
        check($sformatf("v%0d_cyc_release", idx), 32'(wbs_cyc_o), 32'd0);
        @(negedge clk_i);
        check($sformatf("v%0d_back_idle", idx), 32'(dbg_state_o), 32'd0);
    endtask

    // Master doing `beats` consecutive reads from base within one held cyc.
    task automatic master_xfer(input bit m, input logic [31:0] base, input int beats);
        int b;
        int k;
        logic [31:0] a;
        b = 0;
        a = base;
        @(posedge clk_i); #1;
        push_exp(m, a ^ RD_KEY);
        drive_m(m, 1, 1, 0, a, 32'h0, 4'hF);
        while (b < beats) begin
            k = 0;
            do begin
                @(negedge clk_i);
                k++;
            end while (!ack_of(m) && k < 200);
            check($sformatf("m%0d_beat%0d_acked", m, b), 32'(ack_of(m)), 32'd1);
            if (!ack_of(m)) break;
            b++;
            @(posedge clk_i); #1;
            if (b < beats) begin
                a = base + 32'(4 * b);
                push_exp(m, a ^ RD_KEY);
                drive_m(m, 1, 1, 0, a, 32'h0, 4'hF);
            end
        end
        drive_m(m, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic check_order(input string name, input int exp[]);
        check({name, "_count"}, ack_order.size(), exp.size());
        for (int i = 0; i < exp.size() && i < ack_order.size(); i++)
            check($sformatf("%s_%0d", name, i), ack_order[i], exp[i]);
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL global_timeout: simulation did not complete within 100 us");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int t0, t1, nerr, k;
        bit got;

        vecs[0] = '{1'b0, 1'b0, 32'h8000_0010, 32'h0000_0000, 4'hF, 3,  32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'hCAFE_F00D, 4'h3, 1,  32'h5EAD_BFFF};
        vecs[2] = '{1'b1, 1'b0, 32'h1234_5678, 32'h0000_0000, 4'hF, 2,  32'h4C99_E887};
        vecs[3] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0123_4567, 4'h8, 16, 32'hA152_4103};
        vecs[4] = '{1'b1, 1'b0, 32'h8000_0010, 32'h0000_0000, 4'hF, 16, 32'hDEAD_BEEF};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0000_0000, 4'hF, 15, 32'h5EAD_BFFF};

        // reset state
        rst_i = 1'b1;
        drive_m(1'b0, 1, 1, 0, 32'h0, 32'h0, 4'hF);
        drive_m(1'b1, 1, 1, 0, 32'h0, 32'h0, 4'hF);
        #1;
        check("rst_cyc", 32'(wbs_cyc_o), 32'd0);
        check("rst_stb", 32'(wbs_stb_o), 32'd0);
        check("rst_acks", 32'({wbm0_ack_o, wbm1_ack_o}), 32'd0);
        check("rst_errs", 32'({wbm0_err_o, wbm1_err_o}), 32'd0);
        check("rst_state", 32'(dbg_state_o), 32'd0);
        do_reset();

        // single transfers, including ack exactly on the last allowed cycle
        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // simultaneous continuous requests after reset alternate 0,1,0,1,...
        do_reset();
        slave_lat = 2;
        fork
            for (int i = 0; i < 3; i++) master_xfer(1'b0, 32'h0000_1000 + 32'(16 * i), 1);
            for (int i = 0; i < 3; i++) master_xfer(1'b1, 32'h0000_2000 + 32'(16 * i), 1);
        join
        check_order("alternate", '{0, 1, 0, 1, 0, 1});

        // locked: m1 keeps cyc for 3 beats while m0 waits
        do_reset();
        slave_lat = 2;
        fork
            master_xfer(1'b1, 32'h0000_3000, 3);
            begin
                @(posedge clk_i);
                master_xfer(1'b0, 32'h0000_4000, 1);
            end
        join
        check_order("locked", '{1, 1, 1, 0});

        // timeout: slave never acks
        do_reset();
        slave_lat = 0;
        @(posedge clk_i); #1;
        drive_m(1'b0, 1, 1, 0, 32'h0000_5000, 32'h0, 4'hF);
        t0 = -1; t1 = -1; nerr = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            if (t0 < 0 && wbs_stb_o) t0 = c;
            if (wbm0_err_o) begin
                nerr++;
                if (t1 < 0) t1 = c;
            end
            if (t1 >= 0) check($sformatf("drain_cyc_low_%0d", c), 32'(wbs_cyc_o), 32'd0);
        end
        check("timeout_delay", t1 - t0, 16);
        check("timeout_err_pulses", nerr, 1);
        check("timeout_m1_err", 32'(wbm1_err_o), 32'd0);
        check("drain_state", 32'(dbg_state_o), 32'd2);
        @(posedge clk_i); #1;
        force_ack = 1'b1;
        @(negedge clk_i);
        check("drain_ack_blocked", 32'({wbm0_ack_o, wbm1_ack_o}), 32'd0);
        @(posedge clk_i); #1;
        force_ack = 1'b0;
        drive_m(1'b0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        @(negedge clk_i);
        check("drain_hold_until_edge", 32'(dbg_state_o), 32'd2);
        @(negedge clk_i);
        check("drain_to_idle", 32'(dbg_state_o), 32'd0);

        // async reset in the middle of an m1 beat, after m0 was last served
        do_reset();
        slave_lat = 3;
        master_xfer(1'b0, 32'h0000_6000, 1);
        @(posedge clk_i); #1;
        push_exp(1'b1, 32'h0000_7000 ^ RD_KEY);
        drive_m(1'b1, 1, 1, 0, 32'h0000_7000, 32'h0, 4'hF);
        got = 0;
        k   = 0;
        while (!got && k < 10) begin
            @(negedge clk_i);
            k++;
            if (wbm1_ack_o) got = 1;
        end
        check("pre_reset_ack", 32'(got), 32'd1);
        #1;
        rst_i = 1'b1;
        #1;
        check("async_rst_cyc", 32'(wbs_cyc_o), 32'd0);
        check("async_rst_stb", 32'(wbs_stb_o), 32'd0);
        check("async_rst_acks", 32'({wbm0_ack_o, wbm1_ack_o}), 32'd0);
        check("async_rst_errs", 32'({wbm0_err_o, wbm1_err_o}), 32'd0);
        do_reset();
        slave_lat = 2;
        fork
            master_xfer(1'b0, 32'h0000_8000, 1);
            master_xfer(1'b1, 32'h0000_9000, 1);
        join
        check_order("post_reset_tie", '{0, 1});
        check("final_queues_empty", exp0_q.size() + exp1_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_sram_arbiter.md
Name: wb_sram_arbiter

Overview:
- Two-master Wishbone arbiter sharing the single SRAM controller slave port between instruction-fetch (master 0) and data-access (master 1).
- Round-robin grant, held for the whole bus cycle (cyc_i high), so multi-beat locked sequences work.
- Per-transaction watchdog returns an error to the master and frees the bus if the slave never acks.

Parameters:
- ADDR_WIDTH, 32, Wishbone address width.
- DATA_WIDTH, 32, Wishbone data width.
- TIMEOUT_CYCLES, 16, consecutive unacked strobe cycles before timeout; legal range ≥ 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- wbm0_cyc_i, wbm0_stb_i, wbm0_we_i  in  1 each  master 0 control.
- wbm0_adr_i  in  ADDR_WIDTH  master 0 address.
- wbm0_dat_i  in  DATA_WIDTH  master 0 write data.
- wbm0_sel_i  in  DATA_WIDTH/8  master 0 byte selects.
- wbm0_dat_o  out  DATA_WIDTH  read data to master 0.
- wbm0_ack_o, wbm0_err_o  out  1 each  master 0 ack / error.
- wbm1_*  same set and widths as wbm0_*, for master 1.
- wbs_cyc_o, wbs_stb_o, wbs_we_o  out  1 each  slave control.
- wbs_adr_o  out  ADDR_WIDTH  slave address.
- wbs_dat_o  out  DATA_WIDTH  slave write data.
- wbs_sel_o  out  DATA_WIDTH/8  slave byte selects.
- wbs_dat_i  in  DATA_WIDTH  slave read data.
- wbs_ack_i  in  1  slave ack.

Behaviour:
- State machine: IDLE, BUSY, DRAIN. Registers: state, grant (1 bit), last_grant (1 bit), timeout counter (width $clog2(TIMEOUT_CYCLES+1)), err pulse.
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, grant=0, last_grant=1 (master 0 wins the first tie), counter=0, both err=0.
  - Combinationally, all wbs_* control outputs and all ack outputs are 0.
- Request: master k requests when wbmk_cyc_i & wbmk_stb_i.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that master, go to BUSY.
  - Both request: grant the master ≠ last_grant, go to BUSY.
  - The decision is registered. The slave sees the request the cycle after it is first presented, so arbitration latency is 1 cycle.
- BUSY:
  - wbs_cyc_o/stb_o/we_o/adr_o/dat_o/sel_o are combinationally muxed from the granted master.
  - wbs_ack_i goes combinationally to the granted master's ack_o only. The other master's ack_o=0.
  - wbs_dat_i drives both dat_o ports.
  - Grant is held while the granted master's cyc_i=1, including across multiple acked beats.
  - When the granted cyc_i=0: last_grant←grant, go to IDLE, counter←0. The slave cyc is low that cycle.
  - Re-arbitration happens only in IDLE, so back-to-back transfers from different masters have a ≥1-cycle gap.
- Timeout counter:
  - Increments on each BUSY cycle with wbs_stb_o=1 and wbs_ack_i=0.
  - Clears on ack or when stb is low.
  - When counter==TIMEOUT_CYCLES-1 and the cycle is still unacked: next cycle the granted master's err_o=1 for exactly 1 cycle, and state→DRAIN.
  - Ack in the same cycle as the threshold wins: no error.
- DRAIN:
  - All wbs_* controls are forced to 0. Slave acks are discarded, not forwarded.
  - Wait for the granted cyc_i=0, then last_grant←grant, go to IDLE.
- A non-granted master's request is held pending indefinitely. It is never dropped and never gets ack or err.
- err and ack are never both 1 on the same master in the same cycle.
- Reset asserted mid-BUSY: bus released immediately and the slave cyc drops. The slave controller must itself be reset by the same rst_i.

Test Plan:
- Single read: m0 requests adr=0x8000_0010, slave acks after 3 cycles with 0xDEAD_BEEF → wbs_cyc_o rises 1 cycle after the request; wbm0_ack_o pulses with wbm0_dat_o=0xDEAD_BEEF; wbm1_ack_o stays 0.
- Simultaneous requests after reset → m0 served first, then m1 after m0 drops cyc. Repeat with both requesting continuously → grants alternate 0,1,0,1.
- Locked sequence: m1 holds cyc for 3 acked beats while m0 requests → all 3 beats go to m1; m0 is granted only after m1's cyc falls.
- Timeout: TIMEOUT_CYCLES=16, slave never acks → wbm0_err_o=1 for exactly one cycle, 16 cycles after wbs_stb_o first rises; wbs_cyc_o=0 in DRAIN; return to IDLE once m0 drops cyc.
- Ack exactly on cycle 16 of strobe → ack is forwarded and no err.
- Async reset asserted mid-BUSY, between clock edges → wbs_cyc_o/stb_o and all ack/err outputs go to 0 before the next edge; after release, m0 wins a simultaneous request.
